// File: rtl/xoodyak_hash_stream.sv
// xoodyak_hash_stream: streaming Xoodyak hash sponge (absorb, pad, squeeze) around an external Xoodoo unit.
module xoodyak_hash_stream #(
    parameter int DATA_W       = 8,
    parameter int RATE_BYTES   = 16,
    parameter int DIGEST_BYTES = 32
) (
    input  logic                      i_clk,
    input  logic                      i_resetn,
    input  logic                      i_start,
    input  logic [DATA_W-1:0]         i_msg_data,
    input  logic                      i_msg_valid,
    input  logic                      i_msg_last,
    input  logic [$clog2(DATA_W/8):0] i_msg_bytes,
    output logic                      o_msg_ready,
    output logic                      o_perm_start,
    output logic [383:0]              o_perm_state_out,
    input  logic [383:0]              i_perm_state_in,
    input  logic                      i_perm_done,
    output logic [DATA_W-1:0]         o_hash_data,
    output logic                      o_hash_valid,
    output logic                      o_hash_last,
    input  logic                      i_hash_ready,
    output logic                      o_busy,
    output logic                      o_done
);
    localparam int WB = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, ABSORB, PAD, ABS_PERM, SQZ_PERM, OUTPUT, DOWN} state_t;

    state_t             r_state;
    logic [47:0][7:0]   r_s;
    logic [7:0]         r_cd;
    logic [5:0]         r_byte_cnt;
    logic [5:0]         r_blk_cnt;
    logic [8:0]         r_out_cnt;
    logic               r_msg_end;
    logic               r_msg_ready;
    logic               r_perm_start;
    logic [DATA_W-1:0]  r_hash_data;
    logic               r_hash_valid;
    logic               r_hash_last;
    logic               r_busy;
    logic               r_done;

    logic [47:0][7:0]   w_perm;
    logic [5:0]         w_n;
    logic [5:0]         w_byte_nxt;
    logic [5:0]         w_blk_nxt;
    logic [8:0]         w_out_nxt;
    logic               w_in_hs;
    logic               w_out_hs;

    function automatic logic [DATA_W-1:0] word_at(input logic [47:0][7:0] s, input logic [5:0] off);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < WB; k++) w[8*k +: 8] = s[off + 6'(k)];
        return w;
    endfunction

    // Only the last word may be partial; oversize byte counts clamp to a full word.
    assign w_n        = !i_msg_last ? 6'(WB) : (32'(i_msg_bytes) > 32'(WB)) ? 6'(WB) : 6'(i_msg_bytes);
    assign w_byte_nxt = r_byte_cnt + w_n;
    assign w_blk_nxt  = r_blk_cnt + 6'(WB);
    assign w_out_nxt  = r_out_cnt + 9'(WB);
    assign w_in_hs    = r_msg_ready && i_msg_valid;
    assign w_out_hs   = r_hash_valid && i_hash_ready;
    assign w_perm     = i_perm_state_in;

    always_ff @(posedge i_clk) begin
        r_done       <= 1'b0;
        r_perm_start <= 1'b0;
        if (i_resetn) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_cd         <= '0;
            r_byte_cnt   <= '0;
            r_blk_cnt    <= '0;
            r_out_cnt    <= '0;
            r_msg_end    <= 1'b0;
            r_msg_ready  <= 1'b0;
            r_hash_data  <= '0;
            r_hash_valid <= 1'b0;
            r_hash_last  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_state     <= ABSORB;
                    r_s         <= '0;
                    r_cd        <= 8'h03;
                    r_byte_cnt  <= '0;
                    r_out_cnt   <= '0;
                    r_msg_end   <= 1'b0;
                    r_msg_ready <= 1'b1;
                    r_busy      <= 1'b1;
                end
                ABSORB: if (w_in_hs) begin
                    for (int k = 0; k < WB; k++)
                        if (6'(k) < w_n) r_s[r_byte_cnt + 6'(k)] <= r_s[r_byte_cnt + 6'(k)] ^ i_msg_data[8*k +: 8];
                    r_byte_cnt <= w_byte_nxt;
                    r_msg_end  <= i_msg_last;
                    if (i_msg_last || w_byte_nxt == 6'(RATE_BYTES)) begin
                        r_state     <= PAD;
                        r_msg_ready <= 1'b0;
                    end
                end
                PAD: begin
                    r_s[r_byte_cnt] <= r_s[r_byte_cnt] ^ 8'h01;
                    r_s[47]         <= r_s[47] ^ r_cd;
                    r_cd            <= '0;
                    r_perm_start    <= 1'b1;
                    r_state         <= r_msg_end ? SQZ_PERM : ABS_PERM;
                end
                ABS_PERM: if (i_perm_done) begin
                    r_s         <= w_perm;
                    r_byte_cnt  <= '0;
                    r_msg_ready <= 1'b1;
                    r_state     <= ABSORB;
                end
                SQZ_PERM: if (i_perm_done) begin
                    r_s          <= w_perm;
                    r_blk_cnt    <= '0;
                    r_hash_data  <= word_at(w_perm, 6'd0);
                    r_hash_valid <= 1'b1;
                    r_hash_last  <= (w_out_nxt == 9'(DIGEST_BYTES));
                    r_state      <= OUTPUT;
                end
                OUTPUT: if (w_out_hs) begin
                    r_blk_cnt <= w_blk_nxt;
                    r_out_cnt <= w_out_nxt;
                    if (r_hash_last) begin
                        r_hash_valid <= 1'b0;
                        r_hash_last  <= 1'b0;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else if (w_blk_nxt == 6'(RATE_BYTES)) begin
                        r_hash_valid <= 1'b0;
                        r_state      <= DOWN;
                    end else begin
                        r_hash_data <= word_at(r_s, w_blk_nxt);
                        r_hash_last <= (w_out_nxt + 9'(WB) == 9'(DIGEST_BYTES));
                    end
                end
                DOWN: begin
                    r_s[0]       <= r_s[0] ^ 8'h01;
                    r_perm_start <= 1'b1;
                    r_state      <= SQZ_PERM;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_msg_ready      = r_msg_ready;
    assign o_perm_start     = r_perm_start;
    assign o_perm_state_out = r_s;
    assign o_hash_data      = r_hash_data;
    assign o_hash_valid     = r_hash_valid;
    assign o_hash_last      = r_hash_last;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
endmodule

// File: tb/tb_xoodyak_hash_stream.sv
// tb_xoodyak_hash_stream: scoreboard bench; a bench-side permutation stands in for Xoodoo and a
// block-level sponge model predicts every permutation input and digest word.
module tb_xoodyak_hash_stream;
    typedef logic [47:0][7:0] st_t;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [31:0]   msg_data;
    logic          msg_valid;
    logic          msg_last;
    logic [2:0]    msg_bytes;
    logic          hash_ready;
    logic          perm_done;
    logic [383:0]  perm_in;
    logic          o_msg_ready;
    logic          o_perm_start;
    logic [383:0]  o_perm_state_out;
    logic [31:0]   o_hash_data;
    logic          o_hash_valid;
    logic          o_hash_last;
    logic          o_busy;
    logic          o_done;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_hs = 0;
    int            done_cnt = 0;
    logic          done_due = 1'b0;
    logic          resp_en;
    logic [32:0]   exp_hash[$];
    st_t           exp_perm[$];
    st_t           seen_perm[$];
    st_t           cap;
    st_t           hand;

    xoodyak_hash_stream #(.DATA_W(32), .RATE_BYTES(16), .DIGEST_BYTES(32)) dut (
        .i_clk(clk), .i_resetn(resetn), .i_start(start),
        .i_msg_data(msg_data), .i_msg_valid(msg_valid), .i_msg_last(msg_last), .i_msg_bytes(msg_bytes),
        .o_msg_ready(o_msg_ready), .o_perm_start(o_perm_start), .o_perm_state_out(o_perm_state_out),
        .i_perm_state_in(perm_in), .i_perm_done(perm_done),
        .o_hash_data(o_hash_data), .o_hash_valid(o_hash_valid), .o_hash_last(o_hash_last),
        .i_hash_ready(hash_ready), .o_busy(o_busy), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic st_t toy_perm(input st_t s);
        st_t r;
        logic [7:0] b;
        for (int i = 0; i < 48; i++) begin
            b = s[(i + 13) % 48];
            r[i] = s[(i + 7) % 48] ^ {b[6:0], b[7]} ^ 8'(i * 29 + 5);
        end
        return r;
    endfunction

    // Reference sponge: 16-byte blocks, 0x01 pad after the data, Cd=0x03 only on the first block.
    task automatic expect_hash(input logic [7:0] m[$]);
        st_t s = '0;
        logic [7:0] cd = 8'h03;
        int pos = 0;
        int blk;
        do begin
            blk = (m.size() - pos > 16) ? 16 : m.size() - pos;
            for (int j = 0; j < blk; j++) s[j] ^= m[pos + j];
            pos += blk;
            s[blk] ^= 8'h01;
            s[47] ^= cd;
            cd = 8'h00;
            exp_perm.push_back(s);
            s = toy_perm(s);
        end while (pos < m.size());
        for (int w = 0; w < 8; w++) begin
            if (w == 4) begin
                s[0] ^= 8'h01;
                exp_perm.push_back(s);
                s = toy_perm(s);
            end
            exp_hash.push_back({w == 7, s[4*(w%4)+3], s[4*(w%4)+2], s[4*(w%4)+1], s[4*(w%4)]});
        end
    endtask

    // Digest monitor: every valid cycle must show the scoreboard head, so stalls also check holding.
    always @(negedge clk) begin
        if (o_done) done_cnt++;
        if (done_due) begin
            chk("done_after_last", {o_done, o_busy}, 2'b10);
            done_due = 1'b0;
        end else if (o_done) chk("spurious_done", o_done, 1'b0);
        if (o_hash_valid) begin
            if (exp_hash.size() == 0) chk("unexpected_hash", o_hash_valid, 1'b0);
            else begin
                chk("hash_word", {o_hash_last, o_hash_data}, exp_hash[0]);
                if (hash_ready) begin
                    done_due = exp_hash[0][32];
                    void'(exp_hash.pop_front());
                    n_hs++;
                end
            end
        end
    end

    // Permutation responder and input checker.
    always @(negedge clk) if (o_perm_start) begin
        cap = o_perm_state_out;
        seen_perm.push_back(cap);
        if (exp_perm.size() == 0) chk("unexpected_perm", o_perm_start, 1'b0);
        else chk("perm_input", o_perm_state_out, exp_perm.pop_front());
        @(negedge clk);
        chk("perm_start_pulse", o_perm_start, 1'b0);
        if (resp_en) begin
            repeat (2) @(posedge clk);
            #1 perm_in = toy_perm(cap);
            perm_done = 1'b1;
            @(posedge clk);
            #1 perm_done = 1'b0;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t = 0;
        msg_data = d;
        msg_last = last;
        msg_bytes = nb;
        msg_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!o_msg_ready && t < 200);
        if (!o_msg_ready) chk("msg_ready_timeout", o_msg_ready, 1'b1);
        @(posedge clk);
        #1 msg_valid = 1'b0;
    endtask

    task automatic hash_msg(input int len, input logic over);
        logic [7:0] m[$];
        logic [31:0] d;
        logic last;
        int nw, nb, d0, t;
        for (int i = 0; i < len; i++) m.push_back(8'(i));
        expect_hash(m);
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", {o_busy, o_msg_ready}, 2'b11);
        @(posedge clk);
        #1;
        nw = (len + 3) / 4;
        if (nw == 0) nw = 1;
        for (int w = 0; w < nw; w++) begin
            d = 32'hAAAA_AAAA;
            for (int b = 0; b < 4; b++) if (4 * w + b < len) d[8*b +: 8] = m[4 * w + b];
            nb = len - 4 * w;
            if (nb > 4) nb = 4;
            last = (w == nw - 1);
            send_word(d, last, last ? (over ? 3'd7 : 3'(nb)) : 3'd1);
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == d0) chk("done_timeout", 32'(done_cnt), 32'(d0 + 1));
        #1;
    endtask

    task automatic stall();
        int t = 0;
        int h0 = n_hs;
        while (n_hs < h0 + 3 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1 hash_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 hash_ready = 1'b1;
    endtask

    task automatic busy_starts();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    function automatic st_t first_block_hand();
        st_t e = '0;
        for (int i = 0; i < 16; i++) e[i] = 8'(i);
        e[16] = 8'h01;
        e[47] = 8'h03;
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        resetn = 1'b1; start = 1'b0; msg_valid = 1'b0; msg_last = 1'b0; msg_bytes = '0;
        msg_data = '0; hash_ready = 1'b1; perm_done = 1'b0; perm_in = '0; resp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {o_msg_ready, o_perm_start, o_hash_valid, o_hash_last, o_busy, o_done}, 6'b0);
        chk("reset_perm_state", o_perm_state_out, '0);
        chk("reset_hash_data", o_hash_data, '0);
        @(posedge clk);
        #1 resetn = 1'b0;
        msg_valid = 1'b1; msg_last = 1'b1; msg_data = 32'h1234_5678; msg_bytes = 3'd4;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ignores_msg", {o_msg_ready, o_busy}, 2'b00);
        end
        @(posedge clk);
        #1 msg_valid = 1'b0;
        msg_last = 1'b0;

        seen_perm.delete();
        hash_msg(0, 1'b0);
        hand = '0;
        hand[0] = 8'h01;
        hand[47] = 8'h03;
        chk("empty_first_perm", seen_perm[0], hand);
        chk("empty_perm_count", 32'(seen_perm.size()), 32'd2);

        seen_perm.delete();
        hash_msg(16, 1'b0);
        chk("msg16_first_perm", seen_perm[0], first_block_hand());
        chk("msg16_perm_count", 32'(seen_perm.size()), 32'd2);

        seen_perm.delete();
        hash_msg(17, 1'b0);
        chk("msg17_first_perm", seen_perm[0], first_block_hand());
        chk("msg17_perm_count", 32'(seen_perm.size()), 32'd3);

        fork
            hash_msg(16, 1'b0);
            stall();
        join
        fork
            hash_msg(17, 1'b0);
            busy_starts();
        join
        hash_msg(20, 1'b1);

        resp_en = 1'b0;
        seen_perm.delete();
        exp_perm.push_back(first_block_hand());
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int w = 0; w < 4; w++)
            send_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 1'b0, 3'd4);
        t = 0;
        while (seen_perm.size() == 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("abort_perm_issued", 32'(seen_perm.size()), 32'd1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("midperm_reset_ctrl", {o_msg_ready, o_perm_start, o_hash_valid, o_hash_last, o_busy, o_done}, 6'b0);
        chk("midperm_reset_state", o_perm_state_out, '0);
        chk("midperm_reset_hash", o_hash_data, '0);
        @(posedge clk);
        #1 perm_in = {12{32'hDEAD_BEEF}};
        perm_done = 1'b1;
        @(posedge clk);
        #1 perm_done = 1'b0;
        @(negedge clk);
        chk("late_done_state", o_perm_state_out, '0);
        chk("late_done_ctrl", {o_msg_ready, o_hash_valid, o_busy}, 3'b000);
        @(posedge clk);
        #1 resp_en = 1'b1;
        hash_msg(5, 1'b0);

        chk("hash_queue_drained", 32'(exp_hash.size()), 32'd0);
        chk("perm_queue_drained", 32'(exp_perm.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/xoodyak_hash_stream.md
Name: xoodyak_hash_stream

Overview:
- Parametrised successor to the current Xoodyak hash top level.
- Runs the Xoodyak hash-mode sponge (absorb, pad, squeeze) over a streaming message bus of configurable width, with ready/valid flow control on both sides.
- Digest length is configurable and the output is streamed.
- The 384-bit Xoodoo permutation is an external unit, driven through a start/done handshake, so the existing XOODOO instance is reused unchanged.

Parameters:
DATA_W, 8, message/digest bus width in bits; must be a multiple of 8 and divide RATE_BYTES*8.
RATE_BYTES, 16, hash absorb/squeeze rate in bytes (Rhash); range 1..46.
DIGEST_BYTES, 32, digest length in bytes; must be a multiple of DATA_W/8, range 1..255.

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-high (resetn=1 resets on the clk edge)
start  in  1  one-cycle pulse that begins a hash; ignored while busy=1
msg_data  in  DATA_W  message word; byte k sits at bits [8k+7:8k] and is earlier in the stream
msg_valid  in  1  msg_data is valid
msg_last  in  1  final message word
msg_bytes  in  $clog2(DATA_W/8)+1  valid bytes in the last word, 0..DATA_W/8; ignored unless msg_last=1
msg_ready  out  1  block accepts a word
perm_start  out  1  one-cycle pulse; perm_state_out is valid
perm_state_out  out  384  state sent to the permutation; byte i at [8i+7:8i]
perm_state_in  in  384  permuted state
perm_done  in  1  perm_state_in is valid; one-cycle pulse
hash_data  out  DATA_W  digest word, same byte order as msg_data
hash_valid  out  1  hash_data is valid
hash_last  out  1  final digest word
hash_ready  in  1  consumer accepts a word
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the final digest handshake

Behaviour:
- Reset: FSM=IDLE, internal state S=0, counters=0. Outputs msg_ready, perm_start, hash_valid, hash_last, busy and done are 0; perm_state_out and hash_data are 0.
- Reset is honoured in any state, including mid-permutation. A perm_done that arrives after reset is ignored.
- perm_state_out is driven continuously from S.
- States:
  - IDLE: start -> S=0, Cd=0x03, byte_cnt=0, out_cnt=0, go to ABSORB.
  - ABSORB: msg_ready=1.
    - On msg_valid&&msg_ready: XOR the word's bytes into S[byte_cnt..].
    - Non-last word: all DATA_W/8 bytes. Last word: msg_bytes bytes; bytes beyond msg_bytes are ignored.
    - byte_cnt advances by the number of bytes absorbed.
    - Go to PAD when msg_last=1 or byte_cnt reaches RATE_BYTES.
  - PAD (1 cycle, msg_ready=0): S[byte_cnt]^=0x01; S[47]^=Cd; Cd=0x00.
    - If the message ended: go to SQZ_PERM.
    - Otherwise: go to ABS_PERM.
  - ABS_PERM: pulse perm_start in the first cycle, then wait for perm_done.
    - On perm_done: S=perm_state_in, byte_cnt=0, go to ABSORB.
  - SQZ_PERM: same handshake.
    - On perm_done: S=perm_state_in, blk_cnt=0, go to OUTPUT.
  - OUTPUT: hash_valid=1, hash_data=S[blk_cnt .. blk_cnt+DATA_W/8-1].
    - hash_last=1 iff out_cnt+DATA_W/8==DIGEST_BYTES.
    - On handshake: advance blk_cnt and out_cnt.
    - On the last word: pulse done, go to IDLE.
    - Else if blk_cnt reaches RATE_BYTES: go to DOWN.
  - DOWN (1 cycle): S[0]^=0x01 (empty block, Cd=0), go to SQZ_PERM.
- Message framing:
  - Words are aligned to block boundaries; a full non-last word never straddles a block.
  - A full final block (byte_cnt==RATE_BYTES) pads at byte RATE_BYTES; no extra empty block is absorbed.
  - Empty message: a single word with msg_last=1 and msg_bytes=0.
  - msg_bytes>DATA_W/8 is treated as DATA_W/8.
- Handshake rules:
  - hash_data and hash_last are held stable while hash_valid&&!hash_ready.
  - msg_ready is never asserted outside ABSORB.
  - perm_start is never re-asserted before perm_done.
- busy goes low in the same cycle done pulses.
- start pulses in IDLE the cycle after done are accepted.

Test Plan:
- DATA_W=8, empty message (msg_last, msg_bytes=0) -> first perm_state_out has byte0=0x01, byte47=0x03, all other bytes 0; 32 digest bytes match the LWC Xoodyak KAT Count=1; exactly 2 perm_start pulses; done one cycle after the 32nd handshake.
- DATA_W=32, 16-byte message 00..0F -> one absorb block, pad at byte16=0x01, byte47=0x03; 8 output words with hash_last on the 8th; matches the KAT for that message.
- DATA_W=32, 17-byte message -> 3 absorb-side permutations including the squeeze permutation; the second block has byte0=msg[16], byte1=0x01, byte47=0x00.
- Output back-pressure: hash_ready low for 5 cycles mid-digest -> hash_data and hash_last are held; digest unchanged versus a no-stall run.
- resetn asserted while in ABS_PERM, with a late perm_done injected -> all outputs at reset values; the late perm_done is ignored; a new start hashes correctly.
- start asserted while busy, and msg_valid asserted in IDLE -> both ignored; msg_ready stays 0 and the digest is unaffected.
